clk_period_meter: RTL and testbench

- Measures the period and high time of a slow square wave, in clk_in cycles, and reports both with a one-cycle valid strobe.
- Sits directly downstream of the even clock divider and consumes one of its divided outputs (clk_out2/4/8) as sig_in.
- Also usable on any asynchronous low-rate waveform, e.g. as a self-check of divider ratio and 50% duty cycle.

---
 rtl/clk_period_meter.sv | 113 +++++++++++
 tb/tb_clk_period_meter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow asynchronous square wave in clk_in cycles.
// Reports both with a one-cycle valid strobe and flags a missing rising edge as stuck.
module clk_period_meter #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 65535
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             valid,
    output logic             duty_50,
    output logic             stuck
);
    typedef enum logic [1:0] {IDLE, MEASURE, STALL} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sig_s, sig_d, rise;
    logic [CNT_W-1:0]       per_cnt, hi_cnt;
    logic                   at_timeout;
    state_t                 state, state_nxt;
    logic                   arm, capture, count, set_stuck, clr_stuck;

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
            sig_d  <= sig_s;
        end
    end

    assign sig_s      = sync_q[SYNC_STAGES-1];
    assign rise       = sig_s & ~sig_d;
    assign at_timeout = (per_cnt == TIMEOUT_C);

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rise) state_nxt = MEASURE;
            MEASURE: if (!rise && at_timeout) state_nxt = STALL;
            STALL:   if (rise) state_nxt = MEASURE;
            default: state_nxt = IDLE;
        endcase
    end

    // Every rise restarts the counters; only a rise in MEASURE closes a full period.
    always_comb begin
        arm       = 1'b0;
        capture   = 1'b0;
        count     = 1'b0;
        set_stuck = 1'b0;
        clr_stuck = 1'b0;
        case (state)
            IDLE:    arm = rise;
            MEASURE: begin
                arm       = rise;
                capture   = rise;
                count     = !rise;
                set_stuck = !rise && at_timeout;
            end
            STALL: begin
                arm       = rise;
                clr_stuck = rise;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (arm) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else if (count) begin
            if (per_cnt != CNT_MAX)          per_cnt <= per_cnt + 1'b1;
            if (sig_s && hi_cnt != CNT_MAX)  hi_cnt  <= hi_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            period_out <= '0;
            high_out   <= '0;
            valid      <= 1'b0;
            duty_50    <= 1'b0;
            stuck      <= 1'b0;
        end else begin
            valid <= capture;
            if (capture) begin
                period_out <= per_cnt;
                high_out   <= hi_cnt;
                // Doubling is done one bit wider so a large high time cannot alias.
                duty_50    <= ({hi_cnt, 1'b0} == {1'b0, per_cnt});
            end
            if (set_stuck)      stuck <= 1'b1;
            else if (clr_stuck) stuck <= 1'b0;
        end
    end
endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboard bench for clk_period_meter: two instances (wide/narrow counters) share one
// waveform; a sample-level model predicts report, stuck-set and stuck-clear events by cycle.
module tb_clk_period_meter;
    typedef enum int {EV_VALID, EV_SET, EV_CLR} ev_kind_t;
    typedef struct {
        ev_kind_t kind;
        int       cyc;
        int       period;
        int       high;
        int       duty;
    } ev_t;

    logic        clk_in = 1'b0;
    logic        rst    = 1'b0;
    logic        sig    = 1'b0;
    logic [15:0] per_o [2];
    logic [15:0] hi_o  [2];
    logic [1:0]  vld, d50, stk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    ev_t exp_q [2][$];

    always #5 clk_in = ~clk_in;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int CW = (g == 0) ? 16 : 4;
        logic [CW-1:0] p_w, h_w;
        clk_period_meter #(
            .CNT_W      (CW),
            .SYNC_STAGES((g == 0) ? 2 : 3),
            .TIMEOUT    ((g == 0) ? 20 : 15)
        ) dut (
            .clk_in    (clk_in),
            .rst       (rst),
            .sig_in    (sig),
            .period_out(p_w),
            .high_out  (h_w),
            .valid     (vld[g]),
            .duty_50   (d50[g]),
            .stuck     (stk[g])
        );
        assign per_o[g] = 16'(p_w);
        assign hi_o[g]  = 16'(h_w);
    end

    function automatic int tout_of(int i);
        return (i == 0) ? 20 : 15;
    endfunction

    function automatic int ss_of(int i);
        return (i == 0) ? 2 : 3;
    endfunction

    task automatic chk(string nm, int i, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s inst%0d cyc %0d: got %0d, expected %0d", nm, i, cyc, act, exp);
        end
    endtask

    // Reference model: works on the per-cycle samples of sig; a report covers the samples
    // from one rising sample up to the next, provided the gap does not exceed TIMEOUT.
    bit armed [2], stalled [2], prev [2];
    int last_rise [2], hi_cnt [2];

    always @(posedge clk_in) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                armed[i] = 0; stalled[i] = 0; prev[i] = 0; hi_cnt[i] = 0;
                exp_q[i].delete();
            end else begin
                ev_t e;
                if (sig && !prev[i]) begin
                    if (armed[i] && !stalled[i]) begin
                        e.kind = EV_VALID; e.cyc = cyc + ss_of(i);
                        e.period = cyc - last_rise[i]; e.high = hi_cnt[i];
                        e.duty = (2 * e.high == e.period) ? 1 : 0;
                        exp_q[i].push_back(e);
                    end else if (stalled[i]) begin
                        e.kind = EV_CLR; e.cyc = cyc + ss_of(i);
                        e.period = 0; e.high = 0; e.duty = 0;
                        exp_q[i].push_back(e);
                    end
                    armed[i] = 1; stalled[i] = 0; last_rise[i] = cyc; hi_cnt[i] = 1;
                end else if (armed[i] && !stalled[i]) begin
                    if (sig) hi_cnt[i]++;
                    if (cyc - last_rise[i] == tout_of(i)) begin
                        stalled[i] = 1;
                        e.kind = EV_SET; e.cyc = cyc + ss_of(i);
                        e.period = 0; e.high = 0; e.duty = 0;
                        exp_q[i].push_back(e);
                    end
                end
                prev[i] = sig;
            end
        end
    end

    // Monitor: any strobe or stuck transition must match the head of the queue by cycle.
    bit prev_stk [2];
    int exp_p [2], exp_h [2], exp_d [2], exp_s [2];

    always @(negedge clk_in) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                prev_stk[i] = 0; exp_p[i] = 0; exp_h[i] = 0; exp_d[i] = 0; exp_s[i] = 0;
            end else begin
                while (exp_q[i].size() > 0 && exp_q[i][0].cyc < cyc) begin
                    chk("missed_event", i, cyc, exp_q[i][0].cyc);
                    void'(exp_q[i].pop_front());
                end
                if (vld[i] || (stk[i] != prev_stk[i])) begin
                    ev_kind_t act_k;
                    act_k = vld[i] ? EV_VALID : (stk[i] ? EV_SET : EV_CLR);
                    if (exp_q[i].size() == 0) begin
                        chk("unexpected_event", i, int'(act_k), -1);
                    end else if (exp_q[i][0].cyc != cyc) begin
                        chk("event_cycle", i, cyc, exp_q[i][0].cyc);
                    end else begin
                        ev_t e;
                        e = exp_q[i].pop_front();
                        chk("event_kind", i, int'(act_k), int'(e.kind));
                        if (e.kind == EV_VALID) begin
                            exp_p[i] = e.period; exp_h[i] = e.high; exp_d[i] = e.duty;
                        end else begin
                            exp_s[i] = (e.kind == EV_SET) ? 1 : 0;
                        end
                    end
                end
                chk("period_out", i, int'(per_o[i]), exp_p[i]);
                chk("high_out",   i, int'(hi_o[i]),  exp_h[i]);
                chk("duty_50",    i, int'(d50[i]),   exp_d[i]);
                chk("stuck",      i, int'(stk[i]),   exp_s[i]);
                prev_stk[i] = stk[i];
            end
        end
    end

    task automatic drive(int hi_c, int lo_c, int reps);
        for (int r = 0; r < reps; r++) begin
            for (int k = 0; k < hi_c; k++) begin @(negedge clk_in); sig = 1'b1; end
            for (int k = 0; k < lo_c; k++) begin @(negedge clk_in); sig = 1'b0; end
        end
    endtask

    task automatic check_zero(string nm);
        for (int i = 0; i < 2; i++) begin
            chk({nm, "_period"}, i, int'(per_o[i]), 0);
            chk({nm, "_high"},   i, int'(hi_o[i]),  0);
            chk({nm, "_valid"},  i, int'(vld[i]),   0);
            chk({nm, "_duty"},   i, int'(d50[i]),   0);
            chk({nm, "_stuck"},  i, int'(stk[i]),   0);
        end
    endtask

    initial begin
        rst = 1'b0;
        sig = 1'b0;
        repeat (3) @(posedge clk_in);
        #1 check_zero("reset");
        @(negedge clk_in); rst = 1'b1;

        drive(1, 1, 20);           // divide-by-2
        drive(4, 4, 8);            // divide-by-8
        drive(3, 7, 6);            // 3 high / 7 low
        drive(1, 30, 1);           // arm then stall
        drive(2, 3, 4);            // re-arm, period 5
        drive(2, 2, 5);            // divide-by-4, then reset mid-period
        @(negedge clk_in); sig = 1'b1;
        @(posedge clk_in); #3 rst = 1'b0;
        #1 check_zero("async_reset");
        drive(1, 2, 1);
        @(negedge clk_in); rst = 1'b1;
        drive(2, 2, 6);
        drive(6, 6, 3);            // period 12
        drive(7, 7, 3);            // period 14
        drive(5, 10, 3);           // period 15, equal to narrow TIMEOUT
        drive(8, 8, 3);            // period 16: narrow instance stalls
        drive(1, 5, 3);            // single-cycle pulses
        for (int r = 0; r < 30; r++)
            drive(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
        drive(0, 30, 1);           // hold low: both instances end stuck
        repeat (5) @(negedge clk_in);
        for (int i = 0; i < 2; i++) chk("final_stuck", i, int'(stk[i]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
